sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester arbiter that shares one SRAM-like memory port between the instruction-fetch side and the data-access side of the CPU core. It sits between the core's instruction/data request interfaces and the single external bus. It serialises one outstanding transaction at a time. Data side has priority, with a starvation guard that periodically forces an instruction grant.

## Interface
- STARVE_MAX, 4: consecutive contested data grants allowed before a contested cycle must grant inst; range 1..15.

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- inst_req / data_req  in  1  request valid; requester holds it and its fields stable until the matching *_addr_ok
- inst_wr / data_wr  in  1  1 = write, 0 = read
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  32  write data
- inst_wstrb / data_wstrb  in  4  byte enables, writes only
- inst_addr_ok / data_addr_ok  out  1  one-cycle pulse: request accepted by the bus
- inst_data_ok / data_data_ok  out  1  one-cycle pulse: transaction complete
- inst_rdata / data_rdata  out  32  read data, valid with *_data_ok
- bus_req  out  1  downstream request valid
- bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb  out  1/2/32/32/4  latched request fields
- bus_addr_ok  in  1  downstream accepted request
- bus_data_ok  in  1  downstream completion
- bus_rdata  in  32  downstream read data
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, REQ, WAIT. An owner register (INST/DATA) records the requester being served.
- IDLE, no request: remain in IDLE.
- IDLE, winner chosen:
  - Capture the winner's wr/size/addr/wdata/wstrb into bus registers.
  - Set owner to the winner.
  - Go to REQ.
  - For a read, wstrb is captured as 4'b0000.
- Arbitration, evaluated only in IDLE:
  - Only inst_req: grant inst; starve counter ← 0.
  - Only data_req: grant data; counter ← 0.
  - Both requests, counter == STARVE_MAX: grant inst; counter ← 0.
  - Both requests, counter < STARVE_MAX: grant data; counter ← counter + 1.
- REQ:
  - bus_req = 1.
  - On bus_addr_ok: pulse owner's *_addr_ok combinationally in the same cycle, then go to WAIT.
  - bus_data_ok is ignored in this state.
- WAIT:
  - bus_req = 0.
  - On bus_data_ok: pulse owner's *_data_ok and pass bus_rdata to owner's *_rdata combinationally, then go to IDLE.
- Non-owner addr_ok and data_ok are always 0. *_rdata is 0 when the corresponding data_ok is 0.
- Requester fields are not resampled after capture. A requester dropping req in REQ still receives addr_ok (protocol violation, no recovery).
- Reset (rst low, any time, including mid-transaction):
  - State → IDLE; counter → 0; owner → INST.
  - All bus registers → 0.
  - All outputs → 0.
  - An in-flight bus transaction is abandoned; its late bus_data_ok, arriving in IDLE, is ignored.

## Timing
- Request seen in IDLE at cycle 0 → bus_req high from cycle 1.
- Fastest addr_ok: cycle 1 (bus_addr_ok in the same cycle).
- Fastest data_ok: cycle 2. The FSM is in IDLE at cycle 3, where the next grant is decided.
- Minimum issue interval between back-to-back transactions: 3 cycles.
- Downstream guarantees bus_data_ok no earlier than the cycle after bus_addr_ok.
- All state, counter, owner and bus registers update on the rising edge of clk. Reset is asynchronous.
- Reset values: busy 0, bus_req 0, all *_addr_ok / *_data_ok 0, all data and address outputs 0.

## Test plan
- Single inst read:
  - Stimulus: inst_req at cycle 0, addr 0xBFC00000; bus_addr_ok at cycle 1; bus_data_ok at cycle 2 with rdata 0x3C08BFC0.
  - Response: bus_req high during cycle 1 only; inst_addr_ok pulses at cycle 1; inst_data_ok with inst_rdata 0x3C08BFC0 at cycle 2; busy returns to 0 at cycle 3.
- Data write priority:
  - Stimulus: inst_req and data_req both high in IDLE; data write to 0x80001000, wdata 0x12345678, wstrb 4'b1111.
  - Response: bus carries the data fields; data_addr_ok fires, inst_addr_ok stays 0; inst is served in the next transaction.
- Starvation guard (STARVE_MAX=4):
  - Stimulus: both requesters held continuously.
  - Response: grant order is D,D,D,D,I,D,D,D,D,I.
- Slow bus:
  - Stimulus: bus_addr_ok delayed 3 cycles; bus_data_ok delayed 5 cycles after that.
  - Response: bus fields stay stable throughout REQ; exactly one addr_ok pulse and one data_ok pulse to the owner.
- Reset mid-transaction:
  - Stimulus: rst low while in WAIT; then bus_data_ok after reset is released.
  - Response: all outputs 0 immediately; FSM in IDLE; the stray bus_data_ok produces no requester data_ok.
- Read strobe masking:
  - Stimulus: data read with data_wstrb = 4'b1010 driven.
  - Response: bus_wstrb = 4'b0000; bus_wr = 0.

Source files
------------

// File: rtl/sram_arbiter.sv
// Shares one SRAM-style bus port between the instruction-fetch and data-access
// requesters, one transaction in flight, data first with a starvation guard.
module sram_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        inst_req_i,
  input  logic        inst_wr_i,
  input  logic [1:0]  inst_size_i,
  input  logic [31:0] inst_addr_i,
  input  logic [31:0] inst_wdata_i,
  input  logic [3:0]  inst_wstrb_i,
  output logic        inst_addr_ok_o,
  output logic        inst_data_ok_o,
  output logic [31:0] inst_rdata_o,

  input  logic        data_req_i,
  input  logic        data_wr_i,
  input  logic [1:0]  data_size_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [3:0]  data_wstrb_i,
  output logic        data_addr_ok_o,
  output logic        data_data_ok_o,
  output logic [31:0] data_rdata_o,

  output logic        bus_req_o,
  output logic        bus_wr_o,
  output logic [1:0]  bus_size_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_wstrb_o,
  input  logic        bus_addr_ok_i,
  input  logic        bus_data_ok_i,
  input  logic [31:0] bus_rdata_i,

  output logic        busy_o
);

  // state  | meaning
  // S_IDLE | no transaction; arbitration happens here
  // S_REQ  | bus_req asserted, waiting for bus_addr_ok
  // S_WAIT | request accepted, waiting for bus_data_ok
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        any_req;
  logic        both_req;
  logic        grant_data;

  // Data wins unless both are asking and data has already had its quota.
  always_comb begin
    any_req    = inst_req_i | data_req_i;
    both_req   = inst_req_i & data_req_i;
    grant_data = data_req_i & ~(inst_req_i & (cnt_q >= STARVE_LIM));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      owner_q <= OWN_INST;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      wstrb_q <= 4'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_REQ;
          if (grant_data) begin
            owner_d = OWN_DATA;
            wr_d    = data_wr_i;
            size_d  = data_size_i;
            addr_d  = data_addr_i;
            wdata_d = data_wdata_i;
            wstrb_d = data_wr_i ? data_wstrb_i : 4'd0;
            cnt_d   = both_req ? cnt_q + 4'd1 : 4'd0;
          end else begin
            owner_d = OWN_INST;
            wr_d    = inst_wr_i;
            size_d  = inst_size_i;
            addr_d  = inst_addr_i;
            wdata_d = inst_wdata_i;
            wstrb_d = inst_wr_i ? inst_wstrb_i : 4'd0;
            cnt_d   = 4'd0;
          end
        end
      end
      S_REQ: begin
        if (bus_addr_ok_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus_data_ok_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic addr_ok;
  logic data_ok;

  always_comb begin
    addr_ok        = (state_q == S_REQ) & bus_addr_ok_i;
    data_ok        = (state_q == S_WAIT) & bus_data_ok_i;
    inst_addr_ok_o = addr_ok & (owner_q == OWN_INST);
    data_addr_ok_o = addr_ok & (owner_q == OWN_DATA);
    inst_data_ok_o = data_ok & (owner_q == OWN_INST);
    data_data_ok_o = data_ok & (owner_q == OWN_DATA);
    inst_rdata_o   = inst_data_ok_o ? bus_rdata_i : 32'd0;
    data_rdata_o   = data_data_ok_o ? bus_rdata_i : 32'd0;
    bus_req_o      = (state_q == S_REQ);
    busy_o         = (state_q != S_IDLE);
    bus_wr_o       = wr_q;
    bus_size_o     = size_q;
    bus_addr_o     = addr_q;
    bus_wdata_o    = wdata_q;
    bus_wstrb_o    = wstrb_q;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: expected grants are queued when requests
// are driven and checked as the bus side serves each transaction.
module tb_sram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        inst_req_i = 0, inst_wr_i = 0;
  logic [1:0]  inst_size_i = 0;
  logic [31:0] inst_addr_i = 0, inst_wdata_i = 0;
  logic [3:0]  inst_wstrb_i = 0;
  logic        data_req_i = 0, data_wr_i = 0;
  logic [1:0]  data_size_i = 0;
  logic [31:0] data_addr_i = 0, data_wdata_i = 0;
  logic [3:0]  data_wstrb_i = 0;
  logic        bus_addr_ok_i = 0, bus_data_ok_i = 0;
  logic [31:0] bus_rdata_i = 0;
  logic        inst_addr_ok_o, inst_data_ok_o, data_addr_ok_o, data_data_ok_o;
  logic [31:0] inst_rdata_o, data_rdata_o;
  logic        bus_req_o, bus_wr_o, busy_o;
  logic [1:0]  bus_size_o;
  logic [31:0] bus_addr_o, bus_wdata_o;
  logic [3:0]  bus_wstrb_o;

  sram_arbiter #(.STARVE_MAX(4)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .inst_req_i(inst_req_i), .inst_wr_i(inst_wr_i), .inst_size_i(inst_size_i),
    .inst_addr_i(inst_addr_i), .inst_wdata_i(inst_wdata_i), .inst_wstrb_i(inst_wstrb_i),
    .inst_addr_ok_o(inst_addr_ok_o), .inst_data_ok_o(inst_data_ok_o), .inst_rdata_o(inst_rdata_o),
    .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_size_i(data_size_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_wstrb_i(data_wstrb_i),
    .data_addr_ok_o(data_addr_ok_o), .data_data_ok_o(data_data_ok_o), .data_rdata_o(data_rdata_o),
    .bus_req_o(bus_req_o), .bus_wr_o(bus_wr_o), .bus_size_o(bus_size_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_wstrb_o(bus_wstrb_o),
    .bus_addr_ok_i(bus_addr_ok_i), .bus_data_ok_i(bus_data_ok_i), .bus_rdata_i(bus_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        own;    // 0 = inst, 1 = data
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
  } txn_t;

  txn_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_inst(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] rdata);
    txn_t t;
    inst_req_i = 1; inst_wr_i = wr; inst_size_i = size;
    inst_addr_i = addr; inst_wdata_i = wdata; inst_wstrb_i = wstrb;
    t.own = 0; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    t.wstrb = wr ? wstrb : 4'b0000; t.rdata = rdata;
    sb_q.push_back(t);
  endtask

  task automatic set_data(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb, input logic [31:0] rdata);
    txn_t t;
    data_req_i = 1; data_wr_i = wr; data_size_i = size;
    data_addr_i = addr; data_wdata_i = wdata; data_wstrb_i = wstrb;
    t.own = 1; t.wr = wr; t.size = size; t.addr = addr; t.wdata = wdata;
    t.wstrb = wr ? wstrb : 4'b0000; t.rdata = rdata;
    sb_q.push_back(t);
  endtask

  task automatic chk_fields(input string tag, input txn_t e);
    chk({tag, "_wr"},    {31'd0, bus_wr_o},   {31'd0, e.wr});
    chk({tag, "_size"},  {30'd0, bus_size_o}, {30'd0, e.size});
    chk({tag, "_addr"},  bus_addr_o,          e.addr);
    chk({tag, "_wdata"}, bus_wdata_o,         e.wdata);
    chk({tag, "_wstrb"}, {28'd0, bus_wstrb_o}, {28'd0, e.wstrb});
  endtask

  // Plays the downstream bus for the oldest queued grant.
  task automatic serve(input string tag, input int adly, input int ddly, input bit keep);
    txn_t e;
    int   n;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    n = 0;
    @(negedge clk_i);
    while (bus_req_o !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_bus_req"}, {31'd0, bus_req_o}, 32'd1);
    chk_fields(tag, e);
    repeat (adly) begin
      @(negedge clk_i);
      chk({tag, "_req_hold"}, {31'd0, bus_req_o}, 32'd1);
      chk({tag, "_early_aok"}, {30'd0, inst_addr_ok_o, data_addr_ok_o}, 32'd0);
      chk_fields({tag, "_hold"}, e);
    end
    bus_addr_ok_i = 1;
    #1;
    chk({tag, "_addr_ok"}, {30'd0, inst_addr_ok_o, data_addr_ok_o},
        e.own ? 32'd1 : 32'd2);
    @(posedge clk_i); #1;
    bus_addr_ok_i = 0;
    if (!keep) begin
      if (e.own) data_req_i = 0;
      else       inst_req_i = 0;
    end
    repeat (ddly) begin
      @(negedge clk_i);
      chk({tag, "_wait"}, {29'd0, busy_o, bus_req_o, inst_data_ok_o | data_data_ok_o}, 32'd4);
    end
    @(negedge clk_i);
    chk({tag, "_wait_req"}, {31'd0, bus_req_o}, 32'd0);
    bus_data_ok_i = 1;
    bus_rdata_i   = e.rdata;
    #1;
    chk({tag, "_data_ok"}, {30'd0, inst_data_ok_o, data_data_ok_o},
        e.own ? 32'd1 : 32'd2);
    chk({tag, "_inst_rdata"}, inst_rdata_o, e.own ? 32'd0 : e.rdata);
    chk({tag, "_data_rdata"}, data_rdata_o, e.own ? e.rdata : 32'd0);
    @(posedge clk_i); #1;
    bus_data_ok_i = 0;
    bus_rdata_i   = 0;
    @(negedge clk_i);
    chk({tag, "_idle"}, {30'd0, busy_o, bus_req_o}, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, {25'd0, busy_o, bus_req_o, bus_wr_o, inst_addr_ok_o, data_addr_ok_o,
                        inst_data_ok_o, data_data_ok_o}, 32'd0);
    chk({tag, "_addr"},  bus_addr_o, 32'd0);
    chk({tag, "_wdata"}, bus_wdata_o, 32'd0);
    chk({tag, "_misc"},  {26'd0, bus_size_o, bus_wstrb_o}, 32'd0);
    chk({tag, "_rdata"}, inst_rdata_o | data_rdata_o, 32'd0);
  endtask

  initial begin
    int n;
    #2;
    chk_all_zero("reset");
    #20;
    rst_ni = 1;
    @(posedge clk_i); #1;

    // Single instruction read, fastest bus.
    set_inst(0, 2'd2, 32'hBFC0_0000, 32'h0, 4'hF, 32'h3C08_BFC0);
    serve("inst_rd", 0, 0, 0);

    // Both request: data write wins, inst follows.
    set_data(1, 2'd2, 32'h8000_1000, 32'h1234_5678, 4'b1111, 32'h0);
    set_inst(0, 2'd2, 32'hBFC0_0004, 32'h0, 4'h0, 32'h2408_0001);
    serve("prio_d", 0, 0, 0);
    serve("prio_i", 0, 0, 0);

    // Starvation guard: D,D,D,D,I,D,D,D,D,I with both held.
    @(posedge clk_i); #1;
    inst_req_i = 1; inst_wr_i = 0; inst_size_i = 2'd2; inst_addr_i = 32'hBFC0_0100;
    data_req_i = 1; data_wr_i = 0; data_size_i = 2'd1; data_addr_i = 32'h8000_0200;
    data_wstrb_i = 4'b0000;
    for (int k = 0; k < 10; k++) begin
      txn_t t;
      t.own = (k % 5 != 4); t.wr = 0;
      t.size = t.own ? 2'd1 : 2'd2;
      t.addr = t.own ? 32'h8000_0200 : 32'hBFC0_0100;
      t.wdata = t.own ? data_wdata_i : inst_wdata_i;
      t.wstrb = 4'b0000; t.rdata = 32'hA000_0000 + k;
      sb_q.push_back(t);
    end
    for (int k = 0; k < 10; k++) serve($sformatf("starve%0d", k), 0, 0, 1);
    inst_req_i = 0; data_req_i = 0;

    // Slow bus: instruction write held in REQ then WAIT.
    @(posedge clk_i); #1;
    set_inst(1, 2'd0, 32'h0000_0013, 32'hCAFE_F00D, 4'b1000, 32'h5555_AAAA);
    serve("slow", 3, 5, 0);

    // Read with strobes driven: strobes must not reach the bus.
    @(posedge clk_i); #1;
    set_data(0, 2'd2, 32'h8000_2000, 32'hFFFF_FFFF, 4'b1010, 32'h0BAD_BEEF);
    serve("rd_strb", 0, 1, 0);

    // Reset while waiting for completion, then a stray bus_data_ok.
    @(posedge clk_i); #1;
    data_req_i = 1; data_wr_i = 1; data_size_i = 2'd2; data_addr_i = 32'h8000_3000;
    data_wdata_i = 32'h7777_8888; data_wstrb_i = 4'b0011;
    n = 0;
    @(negedge clk_i);
    while (bus_req_o !== 1'b1 && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk("rst_pre_req", {31'd0, bus_req_o}, 32'd1);
    bus_addr_ok_i = 1;
    @(posedge clk_i); #1;
    bus_addr_ok_i = 0;
    data_req_i = 0;
    @(negedge clk_i);
    chk("rst_pre_busy", {31'd0, busy_o}, 32'd1);
    rst_ni = 0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk_i);
    rst_ni = 1;
    bus_data_ok_i = 1;
    bus_rdata_i   = 32'hDEAD_0001;
    #1;
    chk_all_zero("stray");
    @(posedge clk_i); #1;
    bus_data_ok_i = 0;
    bus_rdata_i   = 0;
    @(negedge clk_i);
    chk("stray_idle", {31'd0, busy_o}, 32'd0);

    // Recovery after reset.
    @(posedge clk_i); #1;
    set_inst(0, 2'd2, 32'hBFC0_0380, 32'h0, 4'h0, 32'h1111_2222);
    serve("post_rst", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
